branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Fetch-stage branch predictor. It is the counterpart of the decode-stage branch decision logic: it predicts what that logic will later resolve. It has a direct-mapped BTB with a 2-bit saturating counter per entry and gives a next-PC prediction for the IF-stage PC. It keeps a one-deep record of the prediction for the instruction now in ID, and compares that record against the resolution from decode to produce mispredict/redirect. The table updates from the resolution, and the block holds branch/mispredict performance counters.

Parameters:
ENTRIES, 64, number of BTB entries (power of 2, at least 4); IDX_W = log2(ENTRIES)
CNT_INIT, 2'b01, counter value written on allocation of a not-taken branch

Ports:
clk  in  1  clock; all state on rising edge
Rst  in  1  synchronous active-high reset
if_pc  in  32  PC of the instruction being fetched
if_valid  in  1  if_pc is a real fetch
stall  in  1  IF/ID hold (hazard); record register holds
flush  in  1  IF/ID flush; record cleared
pred_taken  out  1  prediction for if_pc
pred_target  out  32  predicted next PC
res_valid  in  1  ID instruction resolved this cycle (already gated by hazard)
res_cf  in  1  ID instruction is branch, jal or jalr
res_uncond  in  1  ID instruction is jal or jalr
res_taken  in  1  resolved taken (branch_taken)
res_target  in  32  resolved target address
mispredict  out  1  ID prediction was wrong
redirect_pc  out  32  correct next PC when mispredict=1
br_count  out  32  resolved control-flow instructions
mp_count  out  32  mispredictions

Behaviour:
- Index idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Entry fields: valid, tag, target[31:0], uncond, cnt[1:0].
- Lookup is combinational, 0 latency:
  - hit = valid && tag match.
  - pred_taken = if_valid && hit && (uncond || cnt[1]).
  - pred_target = pred_taken ? target : if_pc+4 (32-bit wrap).
- Record register (d_valid, d_pc, d_pred_taken, d_pred_target), updated on the clock edge:
  - Rst -> all cleared.
  - else if stall -> hold.
  - else if flush -> d_valid=0, other fields don't-care.
  - else -> load if_valid, if_pc, pred_taken, pred_target.
  - stall has priority over flush.
- Comparison, active only when res_valid && d_valid:
  - If res_cf: mispredict = (res_taken != d_pred_taken) || (res_taken && res_target != d_pred_target).
  - If !res_cf: mispredict = d_pred_taken (aliased entry).
  - Otherwise mispredict=0.
  - redirect_pc = (res_cf && res_taken) ? res_target : d_pc+4.
- Table update happens on the clock edge when res_valid && d_valid, exactly once per resolution:
  - res_cf && miss: allocate with valid=1, tag, uncond=res_uncond, target=res_target, cnt = res_taken ? 2'b10 : CNT_INIT.
  - res_cf && hit: cnt saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00). target is overwritten only when taken. uncond=res_uncond.
  - !res_cf && hit: valid=0.
  - !res_cf && miss: no change.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents (no bypass).
- Performance counters:
  - br_count +1 when res_valid && d_valid && res_cf.
  - mp_count +1 when mispredict.
  - Both wrap modulo 2^32.
- Reset:
  - On Rst, all valid bits clear in one cycle (table is flops, not RAM). cnt resets to CNT_INIT. Counters reset to 0.
  - Outputs after reset: pred_taken=0, pred_target=if_pc+4, mispredict=0, redirect_pc=d_pc+4=4.
  - Rst mid-operation overrides any simultaneous update or stall.
- Flush in the same cycle as an update: the update still commits (it belongs to the resolving ID instruction).

Decomposition:
- Package bp_pkg holds:
  - typedef bp_entry_t (valid, tag, target, uncond, cnt)
  - counter constants SNT=00, WNT=01, WT=10, ST=11
  - function sat_update(cnt, taken)
- Sub-module btb_table holds the entry array with combinational read port, synchronous write/invalidate port and reset clear.
- branch_predictor holds the record register, compare logic and performance counters.

Test Plan:
- Reset, then if_pc=0x100 with if_valid=1 -> pred_taken=0, pred_target=0x104; br_count=mp_count=0.
- Cold branch at 0x100: resolve res_cf=1, res_taken=1, res_target=0x80 -> mispredict=1, redirect_pc=0x80, mp_count=1. Refetch 0x100 -> pred_taken=1, pred_target=0x80 (cnt=10).
- Same branch resolved not-taken twice -> first resolve mispredict=1, redirect_pc=0x104. cnt goes 10->01->00, and the next fetch gives pred_taken=0. A further not-taken leaves cnt at 00.
- jal at 0x200 -> 0x400 (res_uncond=1) -> after one resolution, every fetch of 0x200 gives pred_taken=1, pred_target=0x400. Repeated resolutions give mispredict=0 and br_count increments each time.
- Aliasing: with ENTRIES=64, a non-CF instruction at 0x1100 maps to the same entry as branch 0x100 but with a different tag -> lookup misses, pred_taken=0, no mispredict. Force a hit by resolving res_cf=0 at 0x100 after it was learned taken -> mispredict=1, redirect_pc=0x104, entry invalidated.
- stall=1 for 3 cycles with res_valid=0, then res_valid=1 -> exactly one update and br_count +1. Rst asserted the cycle after, alongside an update -> table empty and counters 0 next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// A BTB entry stores its tag zero-extended to 32 bits, so the struct is independent of ENTRIES.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic        uncond;
        logic [1:0]  cnt;
    } bp_entry_t;

    // Two-bit saturating counter step: 11 stays 11 on taken, 00 stays 00 on not-taken.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != ST)
            nxt = cnt + 2'b01;
        else if (!taken && cnt != SNT)
            nxt = cnt - 2'b01;
        return nxt;
    endfunction

    // Direction stored in an entry: jumps always go, branches follow the counter MSB.
    function automatic logic entry_dir(input bp_entry_t e);
        return e.uncond || e.cnt[1];
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two combinational read ports and one synchronous write port.
// The table is built from flops, so reset clears every entry in a single cycle.
module btb_table
    import bp_pkg::*;
#(
    parameter int         ENTRIES  = 64,
    parameter logic [1:0] CNT_INIT = WNT,
    parameter int         IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bp_entry_t        rd_entry,
    input  logic [IDX_W-1:0] upd_idx,
    output bp_entry_t        upd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bp_entry_t        wr_entry
);

    bp_entry_t entries [ENTRIES];

    // Reads return the contents before any same-cycle write; there is no bypass.
    assign rd_entry  = entries[rd_idx];
    assign upd_entry = entries[upd_idx];

    // NOTE: every entry is reset here because this array is flops; a RAM-backed table could not be cleared this way.
    always_ff @(posedge clk) begin
        if (Rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i]     <= '0;
                entries[i].cnt <= CNT_INIT;
            end
        end else if (wr_en) begin
            entries[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: BTB lookup for the IF pc, a one-deep record of the prediction for the
// ID instruction, mispredict/redirect against the decode resolution, and performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         ENTRIES  = 64,
    parameter logic [1:0] CNT_INIT = WNT
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [31:0] if_pc,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic        res_cf,
    input  logic        res_uncond,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    bp_entry_t        lk_entry;
    bp_entry_t        upd_entry;
    bp_entry_t        wr_entry;
    logic             wr_en;
    logic             lk_hit;
    logic             upd_hit;
    logic             res_fire;

    logic             d_valid;
    logic [31:0]      d_pc;
    logic             d_pred_taken;
    logic [31:0]      d_pred_target;

    btb_table #(
        .ENTRIES  (ENTRIES),
        .CNT_INIT (CNT_INIT),
        .IDX_W    (IDX_W)
    ) u_btb (
        .clk       (clk),
        .Rst       (Rst),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_entry  (lk_entry),
        .upd_idx   (d_pc[IDX_W+1:2]),
        .upd_entry (upd_entry),
        .wr_en     (wr_en),
        .wr_idx    (d_pc[IDX_W+1:2]),
        .wr_entry  (wr_entry)
    );

    assign lk_hit      = lk_entry.valid && (lk_entry.tag == tag_of(if_pc));
    assign pred_taken  = if_valid && lk_hit && entry_dir(lk_entry);
    assign pred_target = pred_taken ? lk_entry.target : if_pc + 32'd4;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (Rst) begin
            d_valid       <= 1'b0;
            d_pc          <= '0;
            d_pred_taken  <= 1'b0;
            d_pred_target <= '0;
        end else if (!stall) begin
            if (flush) begin
                d_valid <= 1'b0;
            end else begin
                d_valid       <= if_valid;
                d_pc          <= if_pc;
                d_pred_taken  <= pred_taken;
                d_pred_target <= pred_target;
            end
        end
    end

    assign res_fire = res_valid && d_valid;
    assign upd_hit  = upd_entry.valid && (upd_entry.tag == tag_of(d_pc));

    always_comb begin
        mispredict = 1'b0;
        if (res_fire) begin
            if (res_cf)
                mispredict = (res_taken != d_pred_taken) ||
                             (res_taken && res_target != d_pred_target);
            else
                mispredict = d_pred_taken;
        end
    end

    assign redirect_pc = (res_cf && res_taken) ? res_target : d_pc + 32'd4;

    // NOTE: outputs of this block get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = upd_entry;
        if (res_fire) begin
            if (res_cf && !upd_hit) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = tag_of(d_pc);
                wr_entry.uncond = res_uncond;
                wr_entry.target = res_target;
                wr_entry.cnt    = res_taken ? WT : CNT_INIT;
            end else if (res_cf) begin
                wr_en           = 1'b1;
                wr_entry.uncond = res_uncond;
                wr_entry.cnt    = sat_update(upd_entry.cnt, res_taken);
                if (res_taken)
                    wr_entry.target = res_target;
            end else if (upd_hit) begin
                // A non-branch hit means an aliased entry; drop it.
                wr_en          = 1'b1;
                wr_entry.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (res_fire && res_cf)
                br_count <= br_count + 32'd1;
            if (mispredict)
                mp_count <= mp_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: inputs change 1ns after the rising edge, outputs are
// checked before the next edge, and every expected value is hand-derived from the behaviour.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        Rst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_cf;
    logic        res_uncond;
    logic        res_taken;
    logic [31:0] res_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mp_count;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.ENTRIES(64), .CNT_INIT(2'b01)) dut (
        .clk         (clk),
        .Rst         (Rst),
        .if_pc       (if_pc),
        .if_valid    (if_valid),
        .stall       (stall),
        .flush       (flush),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .res_valid   (res_valid),
        .res_cf      (res_cf),
        .res_uncond  (res_uncond),
        .res_taken   (res_taken),
        .res_target  (res_target),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .br_count    (br_count),
        .mp_count    (mp_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        if_valid = 1'b1;
        if_pc    = pc;
    endtask

    task automatic no_fetch();
        if_valid = 1'b0;
        if_pc    = 32'h0;
    endtask

    task automatic resolve(input logic cf, input logic uncond, input logic taken,
                           input logic [31:0] target);
        res_valid  = 1'b1;
        res_cf     = cf;
        res_uncond = uncond;
        res_taken  = taken;
        res_target = target;
    endtask

    task automatic no_res();
        res_valid  = 1'b0;
        res_cf     = 1'b0;
        res_uncond = 1'b0;
        res_taken  = 1'b0;
        res_target = 32'h0;
    endtask

    task automatic check_pred(input string tag, input logic taken, input logic [31:0] target);
        check({tag, "_taken"}, 32'(pred_taken), 32'(taken));
        check({tag, "_target"}, pred_target, target);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] br, input logic [31:0] mp);
        check({tag, "_br"}, br_count, br);
        check({tag, "_mp"}, mp_count, mp);
    endtask

    initial begin
        Rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        no_fetch();
        no_res();
        tick();
        tick();
        Rst = 1'b0;

        // Cold state
        fetch(32'h100);
        #1;
        check_pred("reset_pred", 1'b0, 32'h104);
        check("reset_mp", 32'(mispredict), 32'h0);
        check("reset_redirect", redirect_pc, 32'h4);
        check_cnt("reset", 0, 0);
        tick();

        // Cold taken branch 0x100 -> 0x80
        no_fetch();
        resolve(1'b1, 1'b0, 1'b1, 32'h80);
        #1;
        check("cold_mp", 32'(mispredict), 32'h1);
        check("cold_redirect", redirect_pc, 32'h80);
        tick();

        no_res();
        fetch(32'h100);
        #1;
        check_cnt("after_cold", 1, 1);
        check("bubble_mp", 32'(mispredict), 32'h0);
        check_pred("learned", 1'b1, 32'h80);
        tick();

        // Not-taken #1: lookup in the same cycle still sees cnt=10
        resolve(1'b1, 1'b0, 1'b0, 32'h0);
        fetch(32'h100);
        #1;
        check("nt1_mp", 32'(mispredict), 32'h1);
        check("nt1_redirect", redirect_pc, 32'h104);
        check_pred("no_bypass", 1'b1, 32'h80);
        tick();

        // Not-taken #2: cnt now 01
        #1;
        check("nt2_mp", 32'(mispredict), 32'h1);
        check_pred("cnt01", 1'b0, 32'h104);
        tick();

        // Not-taken #3: cnt 00, prediction was correct
        #1;
        check("nt3_mp", 32'(mispredict), 32'h0);
        check_pred("cnt00", 1'b0, 32'h104);
        tick();

        // Taken once: cnt must go 00 -> 01 (no wrap to 11)
        resolve(1'b1, 1'b0, 1'b1, 32'h80);
        no_fetch();
        #1;
        check_cnt("pre_t", 4, 3);
        check("t_from00_mp", 32'(mispredict), 32'h1);
        tick();

        no_res();
        fetch(32'h100);
        #1;
        check_cnt("post_t", 5, 4);
        check_pred("sat_floor", 1'b0, 32'h104);
        tick();

        resolve(1'b1, 1'b0, 1'b1, 32'h80);
        no_fetch();
        tick();

        no_res();
        fetch(32'h100);
        #1;
        check_pred("relearned", 1'b1, 32'h80);
        tick();

        // Non-CF resolution on a taken-predicted 0x100, while aliased 0x1100 is fetched
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        fetch(32'h1100);
        #1;
        check("alias_hit_mp", 32'(mispredict), 32'h1);
        check("alias_hit_redirect", redirect_pc, 32'h104);
        check_pred("alias_tag_miss", 1'b0, 32'h1104);
        tick();

        fetch(32'h100);
        #1;
        check("alias_miss_mp", 32'(mispredict), 32'h0);
        check_pred("invalidated", 1'b0, 32'h104);
        check_cnt("alias", 6, 6);
        tick();

        // jal 0x200 -> 0x400
        no_res();
        fetch(32'h200);
        tick();

        resolve(1'b1, 1'b1, 1'b1, 32'h400);
        #1;
        check("jal1_mp", 32'(mispredict), 32'h1);
        check("jal1_redirect", redirect_pc, 32'h400);
        check_pred("jal1_pre", 1'b0, 32'h204);
        tick();

        #1;
        check("jal2_mp", 32'(mispredict), 32'h1);
        check_pred("jal2", 1'b1, 32'h400);
        tick();

        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("jal_rep%0d_mp", i), 32'(mispredict), 32'h0);
            check_pred($sformatf("jal_rep%0d", i), 1'b1, 32'h400);
            check($sformatf("jal_rep%0d_br", i), br_count, 32'(8 + i));
            tick();
        end
        check_cnt("jal_done", 10, 8);

        // Stall for 3 cycles with no resolution; flush during a stall must not clear the record
        no_res();
        fetch(32'h300);
        stall = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        stall = 1'b0;
        check_cnt("stalled", 10, 8);

        resolve(1'b1, 1'b1, 1'b1, 32'h400);
        fetch(32'h200);
        #1;
        check("post_stall_mp", 32'(mispredict), 32'h0);
        tick();
        check_cnt("post_stall", 11, 8);

        // Flush alongside an update: update commits, record is cleared
        flush = 1'b1;
        #1;
        check("flush_mp", 32'(mispredict), 32'h0);
        tick();
        flush = 1'b0;
        check_cnt("flush_commit", 12, 8);
        tick();
        check_cnt("after_flush", 12, 8);

        // Reset alongside an update
        no_res();
        fetch(32'h200);
        tick();
        resolve(1'b1, 1'b1, 1'b1, 32'h400);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        no_res();
        #1;
        check_cnt("rst_mid", 0, 0);
        check_pred("rst_empty", 1'b0, 32'h204);
        check("rst_mp", 32'(mispredict), 32'h0);
        check("rst_redirect", redirect_pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
